// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight writers, drives forward selects, load-use stall and flush.
// Optional macro PIPE_HAZARD_FWD_EN compiles operand forwarding in; without it every RAW hazard stalls.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              br_taken,
    output logic              stall,
    output logic              flush,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel,
    output logic [DEPTH-1:0]  stage_valid,
    output logic [15:0]       stall_count,
    output logic [15:0]       flush_count
);

    logic [DEPTH-1:0]  rec_valid;
    logic [DEPTH-1:0]  rec_regwrite;
    logic [DEPTH-1:0]  rec_memread;
    logic [REG_AW-1:0] rec_rd [DEPTH];

    logic [DEPTH-1:0]  match_a;
    logic [DEPTH-1:0]  match_b;
    logic              load_use;
    logic              hazard;

    for (genvar k = 0; k < DEPTH; k++) begin : g_match
        assign match_a[k] = rec_valid[k] && rec_regwrite[k] && (rec_rd[k] != '0) &&
                            (rec_rd[k] == id_rs1) && id_use_rs1 && id_valid;
        assign match_b[k] = rec_valid[k] && rec_regwrite[k] && (rec_rd[k] != '0) &&
                            (rec_rd[k] == id_rs2) && id_use_rs2 && id_valid;
    end

    // A load in EX cannot be forwarded in time, so it is a hazard in either build.
    assign load_use = (match_a[0] || match_b[0]) && rec_memread[0];

`ifdef PIPE_HAZARD_FWD_EN
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_a[k]) sel_a = SEL_W'(k + 1);
            if (match_b[k]) sel_b = SEL_W'(k + 1);
        end
    end

    assign hazard    = load_use;
    assign fwd_a_sel = rst ? sel_a : '0;
    assign fwd_b_sel = rst ? sel_b : '0;
`else
    assign hazard    = load_use || (|match_a) || (|match_b);
    assign fwd_a_sel = '0;
    assign fwd_b_sel = '0;
`endif

    // Redirect wins over a stall: the stalled instruction is on the wrong path anyway.
    assign flush       = br_taken;
    assign stall       = rst && hazard && !br_taken;
    assign stage_valid = rec_valid & {DEPTH{rst}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            rec_valid    <= '0;
            rec_regwrite <= '0;
            rec_memread  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rec_rd[k] <= '0;
            end
            stall_count  <= '0;
            flush_count  <= '0;
        end else begin
            if (stall || flush) begin
                rec_valid    <= {rec_valid[DEPTH-2:0], 1'b0};
                rec_regwrite <= {rec_regwrite[DEPTH-2:0], 1'b0};
                rec_memread  <= {rec_memread[DEPTH-2:0], 1'b0};
                rec_rd[0]    <= '0;
            end else begin
                rec_valid    <= {rec_valid[DEPTH-2:0], id_valid};
                rec_regwrite <= {rec_regwrite[DEPTH-2:0], id_regwrite};
                rec_memread  <= {rec_memread[DEPTH-2:0], id_memread};
                rec_rd[0]    <= id_rd;
            end
            for (int k = 1; k < DEPTH; k++) begin
                rec_rd[k] <= rec_rd[k-1];
            end
            if (stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (flush && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end

endmodule
